// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, back-to-back re-arbitration
// on grant end, and a hold watchdog that forcibly revokes over-long grants.
module rr_onehot_arbiter #(
    parameter int WIDTH    = 10,
    parameter int ID_WIDTH = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [WIDTH-1:0]    request,
    // "release" is a reserved word in SystemVerilog, hence the longer name.
    input  logic                grant_release,
    output logic [WIDTH-1:0]    grant,
    output logic                grant_valid,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                forced_revoke
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam bit WD_ON  = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [ID_WIDTH-1:0] ptr_reg, ptr_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic [WIDTH-1:0]    grant_reg, grant_next;
    logic                valid_reg, valid_next;
    logic [ID_WIDTH-1:0] id_reg, id_next;
    logic                forced_reg, forced_next;

    logic [ID_WIDTH-1:0] ptr_after;
    logic [ID_WIDTH-1:0] search_ptr;
    logic [WIDTH-1:0]    upper_req;
    logic [WIDTH-1:0]    sel_req;
    logic                win_found;
    logic [ID_WIDTH-1:0] win_id;
    logic                expired;
    logic                grant_end;
    logic                forced_end;
    logic                start;

    // While a grant is held, any re-arbitration must already use the advanced pointer.
    assign ptr_after  = (id_reg == LAST_ID) ? '0 : id_reg + ID_WIDTH'(1);
    assign search_ptr = (state_reg == GRANTED) ? ptr_after : ptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_upper
            assign upper_req[gi] = request[gi] & (ID_WIDTH'(gi) >= search_ptr);
        end
    endgenerate

    // Requests at or above the pointer win first; otherwise wrap to the lowest request.
    assign sel_req = (|upper_req) ? upper_req : request;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (sel_req[i]) begin
                win_found = 1'b1;
                win_id    = ID_WIDTH'(i);
            end
        end
    end

    assign expired    = WD_ON && (hold_reg == HOLD_LAST);
    assign grant_end  = (state_reg == GRANTED) && (grant_release || expired);
    assign forced_end = (state_reg == GRANTED) && !grant_release && expired;
    assign start      = enable && win_found;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            hold_reg   <= '0;
            grant_reg  <= '0;
            valid_reg  <= 1'b0;
            id_reg     <= '0;
            forced_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            hold_reg   <= hold_next;
            grant_reg  <= grant_next;
            valid_reg  <= valid_next;
            id_reg     <= id_next;
            forced_reg <= forced_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = start ? GRANTED : IDLE;
            GRANTED: if (grant_end) state_next = start ? GRANTED : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_next  = grant_reg;
        valid_next  = valid_reg;
        id_next     = id_reg;
        ptr_next    = ptr_reg;
        hold_next   = hold_reg;
        forced_next = forced_end;
        if (state_reg == IDLE || grant_end) begin
            hold_next = '0;
            if (grant_end) begin
                ptr_next = ptr_after;
            end
            if (start) begin
                grant_next = {{(WIDTH-1){1'b0}}, 1'b1} << win_id;
                valid_next = 1'b1;
                id_next    = win_id;
            end else begin
                grant_next = '0;
                valid_next = 1'b0;
                id_next    = '0;
            end
        end else begin
            hold_next = hold_reg + HOLD_W'(1);
        end
    end

    assign grant         = grant_reg;
    assign grant_valid   = valid_reg;
    assign grant_id      = id_reg;
    assign forced_revoke = forced_reg;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed and randomised checks for rr_onehot_arbiter: rotation, wrap, watchdog,
// enable gating, reset, and the one-hot output invariants.
module tb_rr_onehot_arbiter;

    localparam int WIDTH    = 10;
    localparam int ID_WIDTH = 4;
    localparam int MAX_HOLD = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic                enable;
    logic [WIDTH-1:0]    request;
    logic                grant_release;
    logic [WIDTH-1:0]    grant;
    logic                grant_valid;
    logic [ID_WIDTH-1:0] grant_id;
    logic                forced_revoke;

    int total  = 0;
    int passed = 0;

    rr_onehot_arbiter #(
        .WIDTH    (WIDTH),
        .ID_WIDTH (ID_WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .request       (request),
        .grant_release (grant_release),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .forced_revoke (forced_revoke)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_grant(input string tag, input logic [31:0] g, input logic [31:0] id,
                                input logic [31:0] forced);
        check({tag, ".grant"}, 32'(grant), g);
        check({tag, ".valid"}, 32'(grant_valid), (g != 0) ? 32'd1 : 32'd0);
        check({tag, ".id"}, 32'(grant_id), id);
        check({tag, ".forced"}, 32'(forced_revoke), forced);
        $display("txn %-12s req=%03h en=%0d rel=%0d -> grant=%03h id=%0d fr=%0d",
                 tag, request, enable, grant_release, grant, grant_id, forced_revoke);
    endtask

    function automatic logic invariant_ok();
        logic ok;
        ok = $onehot0(grant) && (grant_valid == (|grant));
        if (grant == '0) ok = ok && (grant_id == '0);
        else             ok = ok && (grant_id < ID_WIDTH'(WIDTH)) && grant[grant_id];
        return ok;
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b0; request = '0; grant_release = 1'b0;
        tick(2);
        expect_grant("reset", 0, 0, 0);
        reset = 1'b0;

        // Single requester, held past its own request dropping, ended by release.
        request = 10'h004; enable = 1'b1;
        tick();
        expect_grant("single", 32'h004, 2, 0);
        request = '0;
        tick(3);
        expect_grant("hold", 32'h004, 2, 0);
        grant_release = 1'b1;
        tick();
        expect_grant("rel_idle", 0, 0, 0);
        grant_release = 1'b0;

        // Back-to-back rotation from ptr=0 over bits 0,2,4 and wrap.
        reset = 1'b1; tick(); reset = 1'b0;
        request = 10'h015;
        tick();
        expect_grant("rr_b0", 32'h001, 0, 0);
        grant_release = 1'b1;
        tick();
        expect_grant("rr_b2", 32'h004, 2, 0);
        tick();
        expect_grant("rr_b4", 32'h010, 4, 0);
        tick();
        expect_grant("rr_wrap", 32'h001, 0, 0);

        // Pointer at 9 after bit8, then wrap from bit9 to bit0.
        request = 10'h100;
        tick();
        expect_grant("b8", 32'h100, 8, 0);
        request = 10'h201;
        tick();
        expect_grant("ptr9", 32'h200, 9, 0);
        tick();
        expect_grant("wrap9", 32'h001, 0, 0);

        // Watchdog: bit3 never released, revoked 16 cycles after it appears.
        request = 10'h028;
        tick();
        expect_grant("wd_b3", 32'h008, 3, 0);
        grant_release = 1'b0;
        tick(15);
        expect_grant("wd_15", 32'h008, 3, 0);
        tick();
        expect_grant("wd_fire", 32'h020, 5, 1);
        tick();
        expect_grant("wd_after", 32'h020, 5, 0);
        tick(14);
        grant_release = 1'b1;
        tick();
        expect_grant("wd_rel", 32'h008, 3, 0);

        // enable=0 blocks new grants but not a held one.
        enable = 1'b0;
        tick();
        expect_grant("en_drop", 0, 0, 0);
        grant_release = 1'b0; request = 10'h3FF;
        tick(3);
        expect_grant("en_block", 0, 0, 0);
        enable = 1'b1; request = 10'h002;
        tick();
        expect_grant("en_b1", 32'h002, 1, 0);
        enable = 1'b0; request = 10'h3FF;
        tick(3);
        expect_grant("en_held", 32'h002, 1, 0);
        grant_release = 1'b1;
        tick();
        expect_grant("en_rel", 0, 0, 0);
        tick();
        expect_grant("rel_in_idle", 0, 0, 0);
        grant_release = 1'b0;

        // Reset while granted drops everything and returns ptr to 0.
        enable = 1'b1;
        tick();
        expect_grant("pre_rst", 32'h004, 2, 0);
        reset = 1'b1;
        tick();
        expect_grant("mid_rst", 0, 0, 0);
        reset = 1'b0;
        tick();
        expect_grant("post_rst", 32'h001, 0, 0);

        // Random traffic: one-hot contract must hold every cycle.
        for (int c = 0; c < 10000; c++) begin
            request       = WIDTH'($urandom);
            enable        = ($urandom_range(0, 7) != 0);
            grant_release = ($urandom_range(0, 3) == 0);
            reset         = ($urandom_range(0, 499) == 0);
            @(posedge clock);
            #1;
            check("invariant", 32'(invariant_ok()), 32'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
